pf_lanectrl_pause_ctrl: RTL and testbench
=========================================

PF_LANECTRL_PAUSE_CTRL -- requirements
Module: pf_lanectrl_pause_ctrl

Interface
REQ-001 Parameter NUM_LANES, default 4: number of independent pause lanes, legal range 1..16.
REQ-002 Parameter MODE, default 1: 0 = combinational feed-through; 1 = synchronise, stretch and hold off.
REQ-003 Parameter SYNC_STAGES, default 2: input synchroniser flops per lane, legal range 0..3.
REQ-004 Parameter MIN_PAUSE_CYCLES, default 4: minimum output pause width in CLK cycles, legal range 1..16.
REQ-005 Parameter HOLDOFF_CYCLES, default 3: minimum low gap between consecutive output pauses, legal range 0..16.
REQ-006 CLK  in  1  single clock; all state changes on its rising edge.
REQ-007 RESET  in  1  asynchronous, active-high reset.
REQ-008 HS_IO_CLK_PAUSE  in  NUM_LANES  per-lane raw pause request; may be asynchronous to CLK.
REQ-009 HS_IO_CLK_PAUSE_SYNC  out  NUM_LANES  per-lane conditioned pause, driven directly from a flop in MODE 1.
REQ-010 PAUSE_DONE  out  NUM_LANES  per-lane one-cycle pulse marking the end of a pause.
REQ-011 PAUSE_ACTIVE  out  1  OR-reduction of HS_IO_CLK_PAUSE_SYNC.
REQ-012 An out-of-range parameter value SHALL cause an elaboration error.

Function
REQ-013 MODE 0: HS_IO_CLK_PAUSE_SYNC = HS_IO_CLK_PAUSE combinationally; PAUSE_DONE = 0; PAUSE_ACTIVE = OR of the inputs; no state.
REQ-014 MODE 1: each lane passes through a SYNC_STAGES-deep flop chain to a synced signal s; with SYNC_STAGES = 0, s = raw input.
REQ-015 Each lane has its own FSM with states IDLE, PAUSE and HOLDOFF; the pause counter is 4 bits, the holdoff counter 5 bits, and a pend flag is kept.
REQ-016 IDLE: output 0; when s = 1 at an edge, go to PAUSE and load cnt = MIN_PAUSE_CYCLES-1.
REQ-017 PAUSE: output 1; at each edge, if s = 0 and cnt = 0, leave PAUSE, else decrement cnt, saturating at 0.
REQ-018 Leaving PAUSE: go to HOLDOFF with hcnt = HOLDOFF_CYCLES-1, or to IDLE when HOLDOFF_CYCLES = 0; PAUSE_DONE is 1 for exactly the first cycle after exit.
REQ-019 HOLDOFF: output 0; s = 1 at any edge sets pend.
REQ-020 HOLDOFF at hcnt = 0: go to PAUSE (loading cnt as in REQ-016) if pend or s is 1, otherwise to IDLE; pend clears on exit; for hcnt > 0, hcnt decrements.
REQ-021 Latency: an input first sampled high at edge t raises the output after edge t+SYNC_STAGES, i.e. SYNC_STAGES+1 edges.
REQ-022 Width: a synced high of H cycles starting in IDLE yields an output high of exactly max(H, MIN_PAUSE_CYCLES) cycles.
REQ-023 A request during HOLDOFF is never dropped: it is deferred, and the output low gap is exactly HOLDOFF_CYCLES cycles.
REQ-024 A synced pulse that falls and re-rises within PAUSE does not create a second pause or a second PAUSE_DONE.
REQ-025 Lanes are fully independent; simultaneous events on different lanes do not interact.
REQ-026 PAUSE_ACTIVE is 1 whenever any HS_IO_CLK_PAUSE_SYNC bit is 1.

Reset
REQ-027 RESET = 1 immediately clears all synchroniser flops, FSMs (to IDLE), counters, pend, HS_IO_CLK_PAUSE_SYNC, PAUSE_DONE and PAUSE_ACTIVE, without waiting for CLK.
REQ-028 Reset asserted mid-PAUSE or mid-HOLDOFF aborts without a PAUSE_DONE pulse.
REQ-029 After RESET deasserts, the first request is handled as from IDLE.

Verification (NUM_LANES=4, MODE=1, SYNC_STAGES=2, MIN=4, HOLDOFF=3)
REQ-030 Short pulse: lane0 high for 1 cycle, sampled at edge 10 -> SYNC[0] high after edges 12..15 (4 cycles), falls after edge 16; DONE[0] high for the one cycle after edge 16.
REQ-031 Long pulse: lane1 high for 10 cycles from edge 10 -> SYNC[1] high for exactly 10 cycles starting after edge 12; one DONE[1] pulse.
REQ-032 Deferred request: lane0 pulse at edge 10, second 1-cycle pulse at edge 16 -> pend set at edge 18; SYNC[0] re-rises after edge 19 (gap 3 cycles); second pause is 4 cycles.
REQ-033 Parallel lanes: lanes 0..3 pulsed on the same edge with widths 1/2/6/8 -> widths 4/4/6/8; PAUSE_ACTIVE high from after edge 12 until the last lane falls.
REQ-034 Reset mid-pause: RESET pulsed while SYNC[2] = 1 -> all outputs 0 asynchronously, no DONE pulse; after release with inputs at 0, outputs stay 0.
REQ-035 MODE=0: toggle inputs arbitrarily -> SYNC equals the inputs with zero latency; DONE stays 0; PAUSE_ACTIVE equals the OR of the inputs.

Source files
------------

// File: rtl/pf_lanectrl_pause_ctrl.sv
// pf_lanectrl_pause_ctrl: per-lane pause conditioner (sync, stretch, holdoff).
// Ports: CLK, RESET in; HS_IO_CLK_PAUSE[N] in; HS_IO_CLK_PAUSE_SYNC[N], PAUSE_DONE[N], PAUSE_ACTIVE out.
module pf_lanectrl_pause_ctrl #(
  parameter int NUM_LANES        = 4,
  parameter int MODE             = 1,
  parameter int SYNC_STAGES      = 2,
  parameter int MIN_PAUSE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES   = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
  output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC,
  output logic [NUM_LANES-1:0] PAUSE_DONE,
  output logic                 PAUSE_ACTIVE
);

  if (NUM_LANES < 1 || NUM_LANES > 16) begin : g_bad_lanes
    $error("NUM_LANES out of range 1..16");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("MODE must be 0 or 1");
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES out of range 0..3");
  end
  if (MIN_PAUSE_CYCLES < 1 || MIN_PAUSE_CYCLES > 16) begin : g_bad_min
    $error("MIN_PAUSE_CYCLES out of range 1..16");
  end
  if (HOLDOFF_CYCLES < 0 || HOLDOFF_CYCLES > 16) begin : g_bad_hold
    $error("HOLDOFF_CYCLES out of range 0..16");
  end

  typedef enum logic [1:0] {
    IDLE,
    PAUSE,
    HOLDOFF
  } state_t;

  localparam logic [3:0] CNT_LOAD =
    4'(MIN_PAUSE_CYCLES - 1);
  localparam logic [4:0] HCNT_LOAD =
    5'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
  localparam bit HAS_HOLDOFF = (HOLDOFF_CYCLES > 0);

  if (MODE == 0) begin : g_pass
    assign HS_IO_CLK_PAUSE_SYNC = HS_IO_CLK_PAUSE;
    assign PAUSE_DONE           = '0;
  end else begin : g_cond
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic       s;
      logic       out_q;
      logic       done_q;
      logic       pend;
      logic [3:0] cnt;
      logic [4:0] hcnt;
      state_t     state;

      if (SYNC_STAGES == 0) begin : g_nosync
        assign s = HS_IO_CLK_PAUSE[l];
      end else begin : g_sync
        logic [SYNC_STAGES-1:0] sr;
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET) begin
            sr <= '0;
          end else begin
            sr[0] <= HS_IO_CLK_PAUSE[l];
            for (int k = 1; k < SYNC_STAGES; k++)
              sr[k] <= sr[k-1];
          end
        end
        assign s = sr[SYNC_STAGES-1];
      end

      // cnt saturates at 0 so a long request holds PAUSE until s drops.
      // A request seen in HOLDOFF is remembered in pend and served at
      // the end of the gap.
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          state  <= IDLE;
          cnt    <= '0;
          hcnt   <= '0;
          pend   <= 1'b0;
          out_q  <= 1'b0;
          done_q <= 1'b0;
        end else begin
          done_q <= 1'b0;
          unique case (state)
            IDLE: begin
              if (s) begin
                state <= PAUSE;
                cnt   <= CNT_LOAD;
                out_q <= 1'b1;
              end
            end
            PAUSE: begin
              if (!s && cnt == '0) begin
                out_q  <= 1'b0;
                done_q <= 1'b1;
                if (HAS_HOLDOFF) begin
                  state <= HOLDOFF;
                  hcnt  <= HCNT_LOAD;
                end else begin
                  state <= IDLE;
                end
              end else if (cnt != '0) begin
                cnt <= cnt - 4'd1;
              end
            end
            HOLDOFF: begin
              if (hcnt == '0) begin
                pend <= 1'b0;
                if (pend || s) begin
                  state <= PAUSE;
                  cnt   <= CNT_LOAD;
                  out_q <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end else begin
                hcnt <= hcnt - 5'd1;
                if (s) pend <= 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end

      assign HS_IO_CLK_PAUSE_SYNC[l] = out_q;
      assign PAUSE_DONE[l]           = done_q;
    end
  end

  assign PAUSE_ACTIVE = |HS_IO_CLK_PAUSE_SYNC;

endmodule

// File: tb/tb_pf_lanectrl_pause_ctrl.sv
// tb_pf_lanectrl_pause_ctrl: randomized + directed bench for the pause controller.
// Run-length reference model; a MODE 0 instance is checked alongside.
module tb_pf_lanectrl_pause_ctrl;

  localparam int NL   = 4;
  localparam int SS   = 2;
  localparam int MINP = 4;
  localparam int HOLD = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NL-1:0] pin;
  logic [NL-1:0] sync1, done1, sync0, done0;
  logic          act1, act0;

  always #5 clk = ~clk;

  pf_lanectrl_pause_ctrl #(
    .NUM_LANES(NL), .MODE(1), .SYNC_STAGES(SS),
    .MIN_PAUSE_CYCLES(MINP), .HOLDOFF_CYCLES(HOLD)
  ) u_dut (
    .CLK(clk), .RESET(rst),
    .HS_IO_CLK_PAUSE(pin),
    .HS_IO_CLK_PAUSE_SYNC(sync1),
    .PAUSE_DONE(done1),
    .PAUSE_ACTIVE(act1)
  );

  pf_lanectrl_pause_ctrl #(
    .NUM_LANES(NL), .MODE(0), .SYNC_STAGES(SS),
    .MIN_PAUSE_CYCLES(MINP), .HOLDOFF_CYCLES(HOLD)
  ) u_dut0 (
    .CLK(clk), .RESET(rst),
    .HS_IO_CLK_PAUSE(pin),
    .HS_IO_CLK_PAUSE_SYNC(sync0),
    .PAUSE_DONE(done0),
    .PAUSE_ACTIVE(act0)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: output level decided from the length of the current
  // high run / low run, with a deferred-request flag for the gap.
  bit hist [NL][$];
  bit m_out  [NL];
  bit m_done [NL];
  bit m_pend [NL];
  int hi_run [NL];
  int lo_run [NL];

  function automatic void model_reset();
    for (int l = 0; l < NL; l++) begin
      hist[l] = {};
      for (int k = 0; k < SS; k++) hist[l].push_back(1'b0);
      m_out[l]  = 1'b0;
      m_done[l] = 1'b0;
      m_pend[l] = 1'b0;
      hi_run[l] = 0;
      lo_run[l] = 1000;
    end
  endfunction

  function automatic void model_edge(input logic [NL-1:0] raw);
    for (int l = 0; l < NL; l++) begin
      bit s, prev, nxt;
      hist[l].push_back(raw[l]);
      s    = hist[l].pop_front();
      prev = m_out[l];
      if (prev) begin
        nxt = s || (hi_run[l] < MINP);
      end else if (lo_run[l] < HOLD) begin
        nxt = 1'b0;
        if (s) m_pend[l] = 1'b1;
      end else begin
        nxt = s || m_pend[l];
        m_pend[l] = 1'b0;
      end
      if (nxt) begin
        hi_run[l] = prev ? hi_run[l] + 1 : 1;
        lo_run[l] = 0;
      end else begin
        lo_run[l] = prev ? 1 : ((lo_run[l] < 1000) ? lo_run[l] + 1 : 1000);
        hi_run[l] = 0;
      end
      m_done[l] = prev && !nxt;
      m_out[l]  = nxt;
    end
  endfunction

  task automatic check_all();
    logic [NL-1:0] es, ed;
    for (int l = 0; l < NL; l++) begin
      es[l] = m_out[l];
      ed[l] = m_done[l];
    end
    chk("sync",    sync1, es);
    chk("done",    done1, ed);
    chk("active",  act1,  |es);
    chk("m0_sync", sync0, pin);
    chk("m0_done", done0, '0);
    chk("m0_act",  act0,  |pin);
  endtask

  task automatic cycle(input logic [NL-1:0] v);
    pin = v;
    @(posedge clk);
    if (!rst) model_edge(pin);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0);
  endtask

  // Asynchronous reset between edges, held across one edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  int            rem [NL];
  logic [NL-1:0] lvl;

  initial begin
    rst = 1'b1;
    pin = '0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    idle(3);

    // short pulse
    cycle(4'b0001);
    idle(12);

    // deferred request during holdoff
    cycle(4'b0001);
    idle(5);
    cycle(4'b0001);
    idle(15);

    // long pulse on lane 1
    for (int i = 0; i < 10; i++) cycle(4'b0010);
    idle(15);

    // parallel lanes, widths 1/2/6/8
    for (int i = 0; i < 8; i++)
      cycle({i < 8, i < 6, i < 2, i < 1});
    idle(15);

    // reset in the middle of a lane 2 pause
    cycle(4'b0100);
    idle(3);
    chk("pre_rst_sync2", sync1[2], 1'b1);
    do_reset();
    idle(10);

    // randomized run-length traffic with occasional resets
    lvl = '0;
    for (int l = 0; l < NL; l++) rem[l] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int l = 0; l < NL; l++) begin
        if (rem[l] == 0) begin
          lvl[l] = ~lvl[l];
          rem[l] = lvl[l] ? $urandom_range(1, 10)
                          : $urandom_range(1, 14);
        end
        rem[l]--;
      end
      cycle(lvl);
      if ($urandom_range(0, 399) == 0) do_reset();
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
